// File: rtl/count_pwm_gen_if.sv
// Bus between the upstream counter/duty source (master) and count_pwm_gen (slave).
// With PWM_COMPLEMENT_EN defined the bus also carries the dead-timed pwm_n.
interface count_pwm_gen_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] count;
  logic [N:0]   duty_in;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm;
  logic         period_start;
  logic         seq_err;
`ifdef PWM_COMPLEMENT_EN
  logic         pwm_n;

  modport master (
    output count, duty_in, duty_valid,
    input  duty_ready, pwm, period_start, seq_err, pwm_n
  );
  modport slave (
    input  count, duty_in, duty_valid,
    output duty_ready, pwm, period_start, seq_err, pwm_n
  );
`else
  modport master (
    output count, duty_in, duty_valid,
    input  duty_ready, pwm, period_start, seq_err
  );
  modport slave (
    input  count, duty_in, duty_valid,
    output duty_ready, pwm, period_start, seq_err
  );
`endif
endinterface

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: one PWM period per 2^N-cycle period of an upstream free-running
// counter. Duty updates are staged in a one-entry pending slot and only take
// effect at count==0, so the output never glitches mid-period. A break in the
// count sequence drops back to SYNC until the next count==0.
// Optional feature macro: PWM_COMPLEMENT_EN adds pwm_n, a dead-timed complement.
module count_pwm_gen #(
  parameter int unsigned N = 4
) (
  input logic             clk,
  input logic             reset_n,
  count_pwm_gen_if.slave  bus
);

  localparam int unsigned DW = N + 1;
  localparam logic [DW-1:0] DUTY_MAX = DW'(2 ** N);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    count_q;
  logic [N-1:0]    expect_cnt;
  logic [DW-1:0]   active_q, active_d;
  logic [DW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            ready_q, ready_d;
  logic            pwm_q, pwm_d;
  logic            ps_q, ps_d;
  logic            err_q, err_d;
  logic            boundary;
  logic            run_ok;
  logic            accept;
  logic [DW-1:0]   duty_clamped;
`ifdef PWM_COMPLEMENT_EN
  logic            pwm_n_q, pwm_n_d;
`endif

  // Next-state, duty staging and output decode
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    pwm_d        = 1'b0;
    ps_d         = 1'b0;
    err_d        = 1'b0;
    boundary     = 1'b0;
    run_ok       = 1'b0;
    expect_cnt   = count_q + N'(1);
    accept       = bus.duty_valid & ready_q;
    duty_clamped = (bus.duty_in > DUTY_MAX) ? DUTY_MAX : bus.duty_in;

    case (state_q)
      SYNC: begin
        if (bus.count == '0) begin
          state_d  = RUN;
          boundary = 1'b1;
        end
      end
      RUN: begin
        if (bus.count != expect_cnt) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end else begin
          run_ok = 1'b1;
          if (bus.count == '0) begin
            ps_d     = 1'b1;
            boundary = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase

    // Pending duty becomes active only at a period boundary
    if (boundary && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end

    // Compare against the duty in force for this count, including a fresh load at count==0
    if (run_ok) begin
      pwm_d = (DW'(bus.count) < active_d);
    end

    // Accept only into an empty slot; a same-edge boundary load already used the old value
    if (accept) begin
      pend_d      = duty_clamped;
      pend_full_d = 1'b1;
    end

    ready_d = ~pend_full_d;

`ifdef PWM_COMPLEMENT_EN
    // Complement rises one clock after pwm falls, falls together with pwm rising
    pwm_n_d = run_ok & ~pwm_d & ~pwm_q;
`endif
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      count_q     <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
      err_q       <= 1'b0;
`ifdef PWM_COMPLEMENT_EN
      pwm_n_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= bus.count;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
      err_q       <= err_d;
`ifdef PWM_COMPLEMENT_EN
      pwm_n_q     <= pwm_n_d;
`endif
    end
  end

  assign bus.duty_ready   = ready_q;
  assign bus.pwm          = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.seq_err      = err_q;
`ifdef PWM_COMPLEMENT_EN
  assign bus.pwm_n        = pwm_n_q;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen with N=4 (16-clock period). The bench plays
// the upstream counter and the duty source; outputs are sampled 1 time unit
// after each rising edge and tallied per period against hand-computed values.
module tb_count_pwm_gen;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic cnt_en;

  int n_chk  = 0;
  int n_pass = 0;
  int acc_hi, acc_ps, acc_err, acc_nhi, acc_ovl;
  bit done;

  count_pwm_gen_if #(.N(N)) bus ();

  count_pwm_gen #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr_acc();
    acc_hi = 0; acc_ps = 0; acc_err = 0; acc_nhi = 0; acc_ovl = 0;
  endtask

  // One clock: sample outputs after the edge, then advance the upstream counter
  task automatic tick();
    @(posedge clk);
    #1;
    acc_hi  += int'(bus.pwm);
    acc_ps  += int'(bus.period_start);
    acc_err += int'(bus.seq_err);
`ifdef PWM_COMPLEMENT_EN
    acc_nhi += int'(bus.pwm_n);
    acc_ovl += int'(bus.pwm & bus.pwm_n);
`endif
    if (cnt_en) bus.count = bus.count + N'(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge will sample count==0
  task automatic align();
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.count == '0) done = 1'b1;
      else tick();
    end
    if (!done) check("align_timeout", 0, 1);
  endtask

  // Tally one full period starting at count==0
  task automatic measure();
    clr_acc();
    run(16);
  endtask

  // Present a duty value and hold valid until the handshake completes
  task automatic write_duty(input int v);
    bus.duty_in    = (N+1)'(v);
    bus.duty_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (bus.duty_ready) done = 1'b1;
      tick();
    end
    bus.duty_valid = 1'b0;
    if (!done) check("wr_timeout", 0, 1);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_pwm"}, int'(bus.pwm), 0);
    check({tag, "_ps"},  int'(bus.period_start), 0);
    check({tag, "_err"}, int'(bus.seq_err), 0);
    check({tag, "_rdy"}, int'(bus.duty_ready), 1);
`ifdef PWM_COMPLEMENT_EN
    check({tag, "_pwmn"}, int'(bus.pwm_n), 0);
`endif
  endtask

  initial begin
    reset_n        = 1'b0;
    cnt_en         = 1'b0;
    bus.count      = '0;
    bus.duty_in    = '0;
    bus.duty_valid = 1'b0;
    clr_acc();

    // Reset state
    run(3);
    check_outs_zero("rst");

    // Release reset and counter together; first edge samples count 0 -> RUN
    reset_n = 1'b1;
    cnt_en  = 1'b1;
    tick();
    check("sync2run_ps", int'(bus.period_start), 0);
    check("sync2run_pwm", int'(bus.pwm), 0);

    // Test 1: duty 5 before first wrap
    write_duty(5);
    check("t1_rdy_full", int'(bus.duty_ready), 0);
    align();
    measure();
    check("t1_hi", acc_hi, 5);
    check("t1_ps", acc_ps, 1);
    check("t1_err", acc_err, 0);
    check("t1_rdy_free", int'(bus.duty_ready), 1);
`ifdef PWM_COMPLEMENT_EN
    check("t1_nhi", acc_nhi, 10);
    check("t1_ovl", acc_ovl, 0);
`endif
    measure();
    check("t1_hi2", acc_hi, 5);
    check("t1_ps2", acc_ps, 1);

    // Test 2: duty 0, duty 16, duty 31 clamped to 16
    write_duty(0);
    align();
    measure();
    check("t2_hi0", acc_hi, 0);
`ifdef PWM_COMPLEMENT_EN
    check("t2_nhi0", acc_nhi, 16);
`endif
    write_duty(16);
    align();
    measure();
    check("t2_hi16", acc_hi, 16);
`ifdef PWM_COMPLEMENT_EN
    check("t2_nhi16", acc_nhi, 0);
`endif
    write_duty(31);
    align();
    measure();
    check("t2_hi31", acc_hi, 16);
    check("t2_ps31", acc_ps, 1);

    // Test 3: 8 mid-period, then 3 held while ready is low
    run(3);
    write_duty(8);
    check("t3_rdy_low", int'(bus.duty_ready), 0);
    write_duty(3);
    clr_acc();
    run(14);
    check("t3_hi8_tail", acc_hi, 6);
    measure();
    check("t3_hi3", acc_hi, 3);
    check("t3_ps3", acc_ps, 1);
`ifdef PWM_COMPLEMENT_EN
    check("t3_nhi3", acc_nhi, 12);
    check("t3_ovl", acc_ovl, 0);
`endif

    // Test 4: count jump 6 -> 9
    run(7);
    bus.count = N'(9);
    tick();
    check("t4_err_pulse", int'(bus.seq_err), 1);
    check("t4_pwm_err", int'(bus.pwm), 0);
    tick();
    check("t4_err_once", int'(bus.seq_err), 0);
    clr_acc();
    align();
    check("t4_sync_hi", acc_hi, 0);
    check("t4_sync_err", acc_err, 0);
    measure();
    check("t4_resync_hi", acc_hi, 2);
    check("t4_resync_ps", acc_ps, 0);
    measure();
    check("t4_resume_hi", acc_hi, 3);
    check("t4_resume_ps", acc_ps, 1);
    check("t4_resume_err", acc_err, 0);

    // Test 5: one-cycle reset while pwm is high
    run(2);
    check("t5_pre_pwm", int'(bus.pwm), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_outs_zero("t5");
    clr_acc();
    align();
    check("t5_sync_hi", acc_hi, 0);
    measure();
    check("t5_first_hi", acc_hi, 0);
    check("t5_first_ps", acc_ps, 0);
    measure();
    check("t5_dz_hi", acc_hi, 0);
    check("t5_dz_ps", acc_ps, 1);
`ifdef PWM_COMPLEMENT_EN
    check("t5_dz_nhi", acc_nhi, 16);
`endif
    write_duty(5);
    align();
    measure();
    check("t5_new_hi", acc_hi, 5);
`ifdef PWM_COMPLEMENT_EN
    check("t5_new_ovl", acc_ovl, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
